// File: rtl/cfu_ctrl.sv
// cfu_ctrl: issue/completion sequencer between execute and the cfu, with timeout and busy-cycle counter
module cfu_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rslt_o,
  output logic [4:0]  rd_o,
  output logic        err_o,
  output logic [31:0] perf_cnt_o,
  output logic        cfu_en_o,
  output logic [2:0]  cfu_funct3_o,
  output logic [6:0]  cfu_funct7_o,
  output logic [31:0] cfu_src1_o,
  output logic [31:0] cfu_src2_o,
  input  logic        cfu_stall_i,
  input  logic [31:0] cfu_rslt_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      state;
  logic [15:0] tcnt;
  logic        accept;
  assign accept = req_i && (state == IDLE || state == DONE);
  assign busy_o = req_i || state == ISSUE || state == WAIT;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tcnt         <= '0;
      cfu_en_o     <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rslt_o       <= '0;
      rd_o         <= '0;
      perf_cnt_o   <= '0;
      cfu_funct3_o <= '0;
      cfu_funct7_o <= '0;
      cfu_src1_o   <= '0;
      cfu_src2_o   <= '0;
    end else begin
      cfu_en_o <= accept;
      done_o   <= 1'b0;
      if (state == ISSUE || state == WAIT) perf_cnt_o <= perf_cnt_o + 32'd1;
      if (accept) begin
        cfu_funct3_o <= funct3_i;
        cfu_funct7_o <= funct7_i;
        cfu_src1_o   <= src1_i;
        cfu_src2_o   <= src2_i;
        rd_o         <= rd_i;
        state        <= ISSUE;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state == ISSUE) begin
        tcnt  <= '0;
        state <= WAIT;
      end else if (state == WAIT) begin
        if (!cfu_stall_i) begin
          rslt_o <= cfu_rslt_i;
          err_o  <= 1'b0;
          done_o <= 1'b1;
          state  <= DONE;
        end else if (tcnt == 16'(TIMEOUT - 1)) begin
          rslt_o <= '0;
          err_o  <= 1'b1;
          done_o <= 1'b1;
          state  <= DONE;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cfu_ctrl.sv
// tb_cfu_ctrl: directed checks of cfu_ctrl against a small behavioural cfu add unit
module tb_cfu_ctrl;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, err, cfu_en, cfu_stall;
  logic [31:0] rslt, perf, cfu_src1, cfu_src2, cfu_rslt;
  logic [4:0]  rd_q;
  logic [2:0]  cfu_funct3;
  logic [6:0]  cfu_funct7;
  logic        force_stall = 1'b0;
  logic        scnt = 1'b0;
  int          checks = 0, fails = 0;

  always #5 clk = ~clk;

  cfu_ctrl #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .funct3_i(funct3), .funct7_i(funct7),
    .src1_i(src1), .src2_i(src2), .rd_i(rd), .busy_o(busy), .done_o(done),
    .rslt_o(rslt), .rd_o(rd_q), .err_o(err), .perf_cnt_o(perf), .cfu_en_o(cfu_en),
    .cfu_funct3_o(cfu_funct3), .cfu_funct7_o(cfu_funct7), .cfu_src1_o(cfu_src1),
    .cfu_src2_o(cfu_src2), .cfu_stall_i(cfu_stall), .cfu_rslt_i(cfu_rslt)
  );

  // add unit: stall for exactly one cycle after the enable, so stall drops 2 cycles after enable
  always @(posedge clk) scnt <= scnt ? 1'b0 : (cfu_en && cfu_funct3 == 3'd0);
  assign cfu_stall = force_stall | scnt;
  assign cfu_rslt  = (cfu_funct3 == 3'd0) ? cfu_src1 + cfu_src2 : 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    req = 1'b1; funct3 = f3; funct7 = 7'h15; src1 = a; src2 = b; rd = r;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    smp();
    chk("rst_done", done, 0); chk("rst_busy", busy, 0); chk("rst_rslt", rslt, 0);
    chk("rst_rd", rd_q, 0); chk("rst_err", err, 0); chk("rst_perf", perf, 0);
    chk("rst_en", cfu_en, 0); chk("rst_src1", cfu_src1, 0);
    // add 5+7 -> rd 3
    cyc(); cyc(); issue(3'd0, 32'd5, 32'd7, 5'd3);
    smp(); chk("add_busy_t", busy, 1); chk("add_en_t", cfu_en, 0);
    cyc(); smp(); chk("add_en_t1", cfu_en, 1); chk("add_src1", cfu_src1, 5); chk("add_f7", cfu_funct7, 7'h15);
    cyc(); smp(); chk("add_en_t2", cfu_en, 0); chk("add_done_t2", done, 0);
    cyc(); smp(); chk("add_done_t3", done, 0); chk("add_src2_hold", cfu_src2, 7);
    cyc(); smp(); chk("add_done_t4", done, 1); chk("add_rslt", rslt, 12); chk("add_rd", rd_q, 3);
    chk("add_err", err, 0); chk("add_perf", perf, 3);
    cyc(); smp(); chk("add_done_t5", done, 0); chk("add_rslt_hold", rslt, 12); chk("add_busy_t5", busy, 0);
    // wrap-around add
    cyc(); issue(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd9);
    repeat (3) begin cyc(); smp(); chk("wrap_nodone", done, 0); end
    cyc(); smp(); chk("wrap_done", done, 1); chk("wrap_rslt", rslt, 0); chk("wrap_err", err, 0);
    chk("wrap_perf", perf, 6);
    // unsupported funct3
    cyc(); cyc(); issue(3'd3, 32'd9, 32'd4, 5'd2);
    smp(); chk("uns_busy_t", busy, 1);
    cyc(); smp(); chk("uns_busy_t1", busy, 1);
    cyc(); smp(); chk("uns_busy_t2", busy, 1); chk("uns_nodone_t2", done, 0);
    cyc(); smp(); chk("uns_busy_t3", busy, 0); chk("uns_done_t3", done, 1); chk("uns_rslt", rslt, 0);
    chk("uns_err", err, 0); chk("uns_rd", rd_q, 2); chk("uns_perf", perf, 8);
    // timeout with a stuck stall
    cyc(); force_stall = 1'b1; issue(3'd0, 32'd1, 32'd1, 5'd6);
    repeat (9) begin cyc(); smp(); chk("to_nodone", done, 0); end
    cyc(); smp(); chk("to_done", done, 1); chk("to_err", err, 1); chk("to_rslt", rslt, 0);
    chk("to_perf", perf, 17);
    force_stall = 1'b0;
    cyc(); smp(); chk("to_err_hold", err, 1);
    // back-to-back: 1+2 rd1 then 5+5 rd4 issued in the first DONE cycle
    cyc(); cyc(); issue(3'd0, 32'd1, 32'd2, 5'd1);
    repeat (3) cyc();
    cyc(); issue(3'd0, 32'd5, 32'd5, 5'd4);
    smp(); chk("b2b_done1", done, 1); chk("b2b_rslt1", rslt, 3); chk("b2b_rd1", rd_q, 1); chk("b2b_busy_d", busy, 1);
    chk("b2b_err1", err, 0);
    cyc(); smp(); chk("b2b_en_d1", cfu_en, 1); chk("b2b_done_d1", done, 0); chk("b2b_rd_latch", rd_q, 4);
    cyc(); cyc(); smp(); chk("b2b_nodone_d3", done, 0);
    cyc(); smp(); chk("b2b_done2", done, 1); chk("b2b_rslt2", rslt, 10); chk("b2b_rd2", rd_q, 4);
    // reset mid-WAIT
    cyc(); cyc(); issue(3'd0, 32'd2, 32'd2, 5'd6);
    cyc(); cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    smp(); chk("mr_done", done, 0); chk("mr_busy", busy, 0); chk("mr_en", cfu_en, 0); chk("mr_rslt", rslt, 0);
    chk("mr_rd", rd_q, 0); chk("mr_err", err, 0); chk("mr_perf", perf, 0); chk("mr_src1", cfu_src1, 0);
    cyc(); smp(); chk("mr_nodone4", done, 0);
    cyc(); smp(); chk("mr_nodone5", done, 0);
    cyc(); issue(3'd0, 32'd3, 32'd4, 5'd7);
    repeat (3) begin cyc(); smp(); chk("mr_new_nodone", done, 0); end
    cyc(); smp(); chk("mr_new_done", done, 1); chk("mr_new_rslt", rslt, 7); chk("mr_new_rd", rd_q, 7);
    chk("mr_new_perf", perf, 3);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/cfu_ctrl.md
# cfu_ctrl

Issue/completion controller between the core's execute stage and the `cfu` block. It accepts a one-cycle CFU request from the core and latches funct3, funct7, the operands and the destination register. It drives a single-cycle enable into `cfu` and holds those fields stable while the unit stalls, then captures the result and returns it to writeback as a one-cycle done pulse. A timeout guards against a CFU that never releases stall, and a counter tracks CFU-busy cycles.

## Interface
Parameters:
- `TIMEOUT`, 1024: maximum cycles spent in WAIT before forced completion; legal range 2..65535.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in 1: request pulse from execute; sampled in IDLE or DONE only.
- `funct3_i` in 3, `funct7_i` in 7: instruction function fields.
- `src1_i` in 32, `src2_i` in 32: operands.
- `rd_i` in 5: destination register index.
- `busy_o` out 1: core stall request.
- `done_o` out 1: one-cycle completion pulse.
- `rslt_o` out 32: result; valid with `done_o`, held until the next capture.
- `rd_o` out 5: latched destination register; held.
- `err_o` out 1: timeout flag; valid with `done_o`.
- `perf_cnt_o` out 32: count of ISSUE+WAIT cycles.
- `cfu_en_o` out 1: enable to `cfu`.
- `cfu_funct3_o` out 3, `cfu_funct7_o` out 7, `cfu_src1_o` out 32, `cfu_src2_o` out 32: latched fields to `cfu`.
- `cfu_stall_i` in 1: stall from `cfu`.
- `cfu_rslt_i` in 32: result from `cfu`.

## Operation
- Four-state FSM: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `req_i`=1: latch funct3, funct7, src1, src2 and rd into `cfu_*_o` and `rd_o`, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `cfu_en_o`=1.
  - Timeout counter cleared to 0.
  - Always go to WAIT.
- **WAIT**
  - `cfu_en_o`=0; latched fields held unchanged.
  - `cfu_stall_i`=0: `rslt_o`<=`cfu_rslt_i`, `err_o`<=0, go to DONE.
  - `cfu_stall_i`=1 and counter==TIMEOUT-1: `rslt_o`<=0, `err_o`<=1, go to DONE.
  - Otherwise: counter+1, stay in WAIT.
- **DONE**
  - `done_o`=1.
  - `req_i`=1: latch new fields, go to ISSUE (back-to-back issue, no bubble). Otherwise go to IDLE.
  - `rslt_o`, `rd_o` and `err_o` stay held after DONE until the next capture or latch.
- **Outputs and counters**
  - `busy_o` = `req_i` || state==ISSUE || state==WAIT. Combinational on `req_i`, so the core stalls in the request cycle itself.
  - `perf_cnt_o` increments in every ISSUE or WAIT cycle. It wraps 0xFFFFFFFF→0 and is cleared only by reset.
  - Timeout counter is 16 bits.
  - `req_i` in ISSUE or WAIT is ignored; the core is stalled then, so this does not occur in normal operation.
- **Reset**
  - Values: state=IDLE, `cfu_en_o`=0, `done_o`=0, `err_o`=0, `rslt_o`=0, `rd_o`=0, all `cfu_*_o` fields=0, `perf_cnt_o`=0, counter=0.
  - Reset mid-operation abandons the transaction with no `done_o`.
  - The downstream `cfu` has no reset and drains itself: an in-flight add returns to its idle state within 2 cycles with `cfu_en_o`=0. The core must not issue within 2 cycles of reset release.

## Timing
- Request in cycle t: ISSUE at t+1, first WAIT cycle at t+2.
- A CFU that lowers stall N cycles after enable (N≥1) gives DONE/`done_o` at t+2+N.
  - `cfu` add unit (N=2): `done_o` at t+4.
  - Unsupported funct3 (stall low immediately, N=0 seen from WAIT): `done_o` at t+3.
- Timeout: WAIT lasts at most TIMEOUT cycles, so `done_o` with `err_o`=1 arrives at t+2+TIMEOUT.
- Back-to-back: a request in the DONE cycle d gives ISSUE at d+1.

## Test plan
- Add with a real `cfu`: req at t with funct3=0, src1=5, src2=7, rd=3 → `cfu_en_o`=1 only at t+1; `done_o` at t+4 with `rslt_o`=12, `rd_o`=3, `err_o`=0; `perf_cnt_o`=3.
- Wrap-around add: src1=0xFFFFFFFF, src2=1 → `rslt_o`=0x00000000, `err_o`=0, `done_o` at t+4.
- Unsupported op: funct3=3, src1=9 → `done_o` at t+3, `rslt_o`=0, `err_o`=0; `busy_o` high at t, t+1, t+2 and low at t+3.
- Timeout: TIMEOUT=8, stub holds `cfu_stall_i`=1 → `done_o` at t+10 with `err_o`=1, `rslt_o`=0; `perf_cnt_o`=9.
- Back-to-back: second req (5+5, rd=4) asserted in the first DONE cycle → second ISSUE the next cycle; second `done_o` 4 cycles after the first, `rslt_o`=10, `rd_o`=4; first result was visible during the first `done_o`.
- Reset mid-WAIT: `rst_i` high for one cycle at t+2 → from t+3 state is IDLE and all outputs are at reset values; no `done_o`; a new request at t+6 completes normally at t+10.
